// File: rtl/c2_radix4_mult_ctrl_pkg.sv
// Shared types and helpers for the C2-style radix-4 multiplier controller.
package c2_mult_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PRECOMP = 2'd1,
    RUN     = 2'd2,
    DONE    = 2'd3
  } state_e;

  // Width of the iteration counter: enough bits to count WIDTH/2 steps,
  // never narrower than one bit.
  function automatic int iterWidth(input int width);
    int w;
    w = $clog2(width / 2);
    if (w < 1) w = 1;
    return w;
  endfunction

endpackage

// File: rtl/c2_radix4_mult_ctrl_pp_sel.sv
// C2 4:1 partial-product select: 00 -> 0, 01 -> A, 10 -> 2A, 11 -> 3A.
module c2_pp_sel #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH+1:0] a3_i,
  input  logic [1:0]       sel_i,
  output logic [WIDTH+1:0] pp_o
);

  logic s1;
  logic s0;

  assign s1 = sel_i[1];
  assign s0 = sel_i[0];

  // Select the zero-extended multiple of A named by the two multiplier bits.
  always_comb begin
    pp_o = '0;
    case ({s1, s0})
      2'b00:   pp_o = '0;
      2'b01:   pp_o = {2'b00, a_i};
      2'b10:   pp_o = {1'b0, a_i, 1'b0};
      default: pp_o = a3_i;
    endcase
  end

endmodule

// File: rtl/c2_radix4_mult_ctrl.sv
// Sequential unsigned radix-4 shift-add multiplier controller.
// Optional build macro: C2_MULT_ZERO_BYPASS_EN - a zero operand skips the
// iterations and reports a zero product one cycle after the start.
module c2_radix4_mult_ctrl
  import c2_mult_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  localparam int ITER = WIDTH / 2;
  localparam int IW = iterWidth(WIDTH);
  localparam logic [IW-1:0] ITER_LAST = IW'(ITER - 1);

  if ((WIDTH < 4) || ((WIDTH % 2) != 0)) begin : gBadWidth
    $error("c2_radix4_mult_ctrl: WIDTH must be even and at least 4");
  end

  state_e               state_q;
  logic [WIDTH-1:0]     a_q;
  logic [WIDTH-1:0]     b_q;
  logic [WIDTH+1:0]     a3_q;
  logic [2*WIDTH+1:0]   acc_q;
  logic [IW-1:0]        iter_q;
  logic                 busy_q;
  logic                 done_q;
  logic [2*WIDTH-1:0]   product_q;

  logic [WIDTH+1:0]     ppSel;
  logic [WIDTH+2:0]     accSum;
  logic [2*WIDTH+1:0]   acc_d;
  logic                 zeroStart;
  logic                 unusedShiftBits;

  c2_pp_sel #(.WIDTH(WIDTH)) uPpSel (
    .a_i   (a_q),
    .a3_i  (a3_q),
    .sel_i (b_q[1:0]),
    .pp_o  (ppSel)
  );

  // Add the selected partial product into the upper half, keep the carry,
  // then shift the whole accumulator right by one radix-4 digit.
  assign accSum = {1'b0, acc_q[2*WIDTH+1:WIDTH]} + {1'b0, ppSel};
  assign acc_d  = {1'b0, accSum, acc_q[WIDTH-1:2]};

  // The two bits shifted out each step only ever carry the initial zeros.
  assign unusedShiftBits = ^acc_q[1:0];

`ifdef C2_MULT_ZERO_BYPASS_EN
  assign zeroStart = (a == '0) || (b == '0);
`else
  assign zeroStart = 1'b0;
`endif

  // Controller FSM with registered handshake outputs and product.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      a_q       <= '0;
      b_q       <= '0;
      a3_q      <= '0;
      acc_q     <= '0;
      iter_q    <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      product_q <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE, DONE: begin
          if (start) begin
            a_q   <= a;
            b_q   <= b;
            acc_q <= '0;
            if (zeroStart) begin
              state_q   <= DONE;
              done_q    <= 1'b1;
              product_q <= '0;
            end else begin
              state_q <= PRECOMP;
              busy_q  <= 1'b1;
            end
          end else begin
            state_q <= IDLE;
          end
        end
        PRECOMP: begin
          a3_q    <= {2'b00, a_q} + {1'b0, a_q, 1'b0};
          iter_q  <= '0;
          state_q <= RUN;
        end
        RUN: begin
          acc_q  <= acc_d;
          b_q    <= b_q >> 2;
          iter_q <= iter_q + 1'b1;
          if (iter_q == ITER_LAST) begin
            state_q   <= DONE;
            busy_q    <= 1'b0;
            done_q    <= 1'b1;
            product_q <= acc_d[2*WIDTH-1:0];
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign product = product_q;

endmodule

// File: tb/tb_c2_radix4_mult_ctrl.sv
// Self-checking bench for c2_radix4_mult_ctrl at WIDTH=8.
// Honours C2_MULT_ZERO_BYPASS_EN when choosing expected zero-operand latency.
module tb_c2_radix4_mult_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [7:0]  a = '0;
  logic [7:0]  b = '0;
  logic        busy;
  logic        done;
  logic [15:0] product;

  int total = 0;
  int bad = 0;

`ifdef C2_MULT_ZERO_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  typedef struct {
    logic [7:0]  a;
    logic [7:0]  b;
    logic [15:0] p;
  } vec_t;

  vec_t vecs[10];

  c2_radix4_mult_ctrl #(.WIDTH(8)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .a       (a),
    .b       (b),
    .busy    (busy),
    .done    (done),
    .product (product)
  );

  // Free-running clock, 10 time units per cycle.
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("[TB] FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  // Pulse start for one cycle; afterwards scramble the operands, which the
  // design must ignore while it works.
  task automatic applyStimulus(input logic [7:0] av, input logic [7:0] bv);
    start = 1'b1;
    a = av;
    b = bv;
    tick();
    start = 1'b0;
    a = 8'($urandom);
    b = 8'($urandom);
  endtask

  function automatic int latFor(input logic [7:0] av, input logic [7:0] bv);
    return (BYPASS && ((av == 0) || (bv == 0))) ? 1 : 6;
  endfunction

  // Wait (bounded) for done, counting cycles since the accepting edge.
  task automatic waitDone(input string name, input int startLat, input int expLat,
                          input longint expProd);
    int lat;
    int busyLow;
    lat = startLat;
    busyLow = 0;
    while (!done && lat < 40) begin
      if (!busy) busyLow++;
      tick();
      lat++;
    end
    checkOutput({name, "_latency"}, lat, expLat);
    checkOutput({name, "_product"}, product, expProd);
    checkOutput({name, "_busyLowDuringOp"}, busyLow, 0);
    checkOutput({name, "_busyAtDone"}, busy, 0);
  endtask

  initial begin
    int doneCount;
    logic [7:0] ra;
    logic [7:0] rb;

    vecs[0] = '{8'd255, 8'd255, 16'd65025};
    vecs[1] = '{8'd13,  8'd11,  16'd143};
    vecs[2] = '{8'd1,   8'd1,   16'd1};
    vecs[3] = '{8'd128, 8'd2,   16'd256};
    vecs[4] = '{8'd3,   8'd3,   16'd9};
    vecs[5] = '{8'd170, 8'd85,  16'd14450};
    vecs[6] = '{8'd0,   8'd77,  16'd0};
    vecs[7] = '{8'd77,  8'd0,   16'd0};
    vecs[8] = '{8'd255, 8'd1,   16'd255};
    vecs[9] = '{8'd2,   8'd255, 16'd510};

    rst_n = 1'b0;
    tick();
    tick();
    checkOutput("resetBusy", busy, 0);
    checkOutput("resetDone", done, 0);
    checkOutput("resetProduct", product, 0);
    rst_n = 1'b1;
    tick();

    for (int i = 0; i < 10; i++) begin
      applyStimulus(vecs[i].a, vecs[i].b);
      waitDone($sformatf("vec%0d", i), 1, latFor(vecs[i].a, vecs[i].b), vecs[i].p);
      tick();
      checkOutput($sformatf("vec%0d_donePulse", i), done, 0);
      checkOutput($sformatf("vec%0d_productHeld", i), product, vecs[i].p);
    end

    // Back-to-back: new start accepted in the DONE cycle.
    applyStimulus(8'd13, 8'd11);
    waitDone("b2bFirst", 1, 6, 143);
    start = 1'b1;
    a = 8'd200;
    b = 8'd3;
    tick();
    start = 1'b0;
    checkOutput("b2bProductHeld", product, 143);
    checkOutput("b2bBusy", busy, 1);
    waitDone("b2bSecond", 1, 6, 600);
    tick();

    // Start pulse while busy must be ignored.
    applyStimulus(8'd9, 8'd7);
    tick();
    start = 1'b1;
    a = 8'd1;
    b = 8'd1;
    tick();
    start = 1'b0;
    waitDone("ignoredStart", 3, 6, 63);
    doneCount = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (done) doneCount++;
    end
    checkOutput("ignoredStartExtraDone", doneCount, 0);
    checkOutput("ignoredStartProduct", product, 63);

    // Reset during RUN iteration 2 abandons the op.
    applyStimulus(8'd100, 8'd50);
    tick();
    tick();
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    checkOutput("midResetBusy", busy, 0);
    checkOutput("midResetDone", done, 0);
    checkOutput("midResetProduct", product, 0);
    doneCount = 0;
    for (int i = 0; i < 10; i++) begin
      if (done || busy) doneCount++;
      tick();
    end
    checkOutput("midResetNoActivity", doneCount, 0);
    applyStimulus(8'd6, 8'd7);
    waitDone("afterReset", 1, 6, 42);
    tick();

    // Random operands against the bench's own multiply.
    for (int i = 0; i < 200; i++) begin
      ra = 8'($urandom);
      rb = 8'($urandom);
      applyStimulus(ra, rb);
      waitDone($sformatf("rand%0d", i), 1, latFor(ra, rb), longint'(ra) * longint'(rb));
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/c2_radix4_mult_ctrl.md
Name: c2_radix4_mult_ctrl

Overview:
Sequential unsigned radix-4 shift-add multiplier controller built around the C2-style 4:1 partial-product select (d00=0, d01=A, d10=2A, d11=3A).
- Sequences the select over WIDTH/2 iterations and owns the accumulator.
- Exposes a start/busy/done handshake to the surrounding multiplier datapath.

Parameters:
- WIDTH, 8, operand width in bits; must be even and ≥4; elaboration error otherwise.
- ITER, WIDTH/2, iteration count (localparam, derived, not overridable).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous active-low reset.
- start  input  1  request; accepted only when busy=0.
- a  input  WIDTH  multiplicand; sampled at accepted start.
- b  input  WIDTH  multiplier; sampled at accepted start.
- busy  output  1  high in PRECOMP and RUN.
- done  output  1  one-cycle pulse when product is valid.
- product  output  2*WIDTH  result; held until next accepted start.

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - state=IDLE.
  - busy=0, done=0, product=0, internal registers=0.
  - Applies mid-operation too: the op is abandoned and no done is produced.
- States:
  - IDLE: on start, latch a into A_r and b into B_r, clear acc, go to PRECOMP.
  - PRECOMP: one cycle; A3_r = A_r + (A_r<<1), WIDTH+2 bits; iter=0; go to RUN.
  - RUN: each cycle:
    - sel = B_r[1:0]; pp = {0, A_r, A_r<<1, A3_r}[sel], WIDTH+2 bits, zero-extended.
    - acc_hi = acc_hi + pp, carry kept.
    - acc shifted right by 2; B_r shifted right by 2; iter++.
    - After iter==ITER-1, go to DONE.
  - DONE: product=acc[2*WIDTH-1:0]; done=1 for exactly this cycle. Next state is IDLE, or PRECOMP if start=1 this cycle.
- Accumulator width is 2*WIDTH+2; the final upper 2 bits are always 0 for unsigned operands. No overflow is possible.
- Latency: start accepted at edge N gives done=1 in cycle N+ITER+2 (WIDTH=8: 6 cycles).
- Throughput: back-to-back, one result per ITER+2 cycles.
- start while busy=1 is ignored; a/b changes are ignored while busy.
- start in the DONE cycle is accepted: operands are latched, and product still updates with the old result in that cycle.
- product updates only on entry to DONE. It is otherwise stable, including across ignored starts.

Optional Feature:
Macro C2_MULT_ZERO_BYPASS_EN.
- Defined:
  - An accepted start with a==0 or b==0 goes IDLE→DONE directly.
  - done is asserted in the next cycle (latency 1) with product=0.
  - busy stays 0.
- Undefined: zero operands take the full ITER+2 cycles; product=0.

Decomposition:
- Shared package c2_mult_pkg:
  - state enum {IDLE, PRECOMP, RUN, DONE} with a 2-bit encoding.
  - Helper function for iteration-counter width, $clog2(WIDTH/2) with a minimum of 1.
- Sub-module c2_pp_sel:
  - Purely combinational, parameter WIDTH.
  - Inputs A, A3, sel[1:0]; output pp[WIDTH+1:0].
  - Uses C2 select semantics: s1=sel[1], s0=sel[0], d00=0, d01=A, d10=A<<1, d11=A3.

Test Plan:
- WIDTH=8, a=255, b=255, start at cycle 0 → busy cycles 1–5; done=1 at cycle 6 only; product=65025.
- a=13, b=11 → product=143 after 6 cycles. Then a=200, b=3 with start in the DONE cycle → second done 6 cycles later, product=600.
- start pulse at cycle 2 of an active op with a=1, b=1 → ignored; first op's product unchanged; no extra done.
- rst_n=0 at RUN iteration 2, then released → busy=0, done=0, product=0. No done until a new start.
- a=0, b=77 → with C2_MULT_ZERO_BYPASS_EN: done at cycle 1, busy never high, product=0. Without it: done at cycle 6, product=0.
- Random unsigned a, b, 1000 ops, WIDTH=8 and WIDTH=16 → product==a*b; done latency exactly ITER+2.
